// File: rtl/alu_result_stage_pkg.sv
// Shared definitions for the ALU result stage: op codes, occupancy encodings
// and the packed flag bundle stored with every buffered result.
package alu_result_stage_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;
  localparam logic [2:0] OP_SLT = 3'd7;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
  } flags_t;

  // Carry and overflow only mean something for the adder operations.
  function automatic logic is_arith(input logic [2:0] ctl);
    return (ctl == OP_ADD) || (ctl == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Producer/consumer bundle around the result stage. The master side feeds
// results and accepts heads; the slave side is the stage itself.
interface alu_result_stage_if #(parameter int WIDTH = 32);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic [2:0]       in_ctl;
  logic             in_carry;
  logic             in_ovf;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [2:0]       out_ctl;
  logic             out_zero;
  logic             out_neg;
  logic             out_carry;
  logic             out_ovf;

  modport master (
    output in_valid, in_result, in_ctl, in_carry, in_ovf, out_ready,
    input  in_ready, out_valid, out_result, out_ctl, out_zero, out_neg,
           out_carry, out_ovf
  );

  modport slave (
    input  in_valid, in_result, in_ctl, in_carry, in_ovf, out_ready,
    output in_ready, out_valid, out_result, out_ctl, out_zero, out_neg,
           out_carry, out_ovf
  );

endinterface

// File: rtl/alu_result_stage_flag_gen.sv
// Combinational flag generation on the input side of the result stage.
module alu_flag_gen
  import alu_result_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] result_i,
  input  logic [2:0]       ctl_i,
  input  logic             carry_i,
  input  logic             ovf_i,
  output flags_t           flags_o
);

  // Zero/negative always apply; carry/overflow are masked off for logic ops.
  always_comb begin
    flags_o.zero  = (result_i == '0);
    flags_o.neg   = result_i[WIDTH-1];
    flags_o.carry = carry_i & is_arith(ctl_i);
    flags_o.ovf   = ovf_i & is_arith(ctl_i);
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: two-entry skid buffer behind valid/ready with
// per-entry flags and a sticky overflow indicator for the consumer.
module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  alu_result_stage_if.slave bus,
  input  logic          clr_sticky_i,
  output logic          sticky_ovf_o
);

  logic [1:0]       state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] head_result_q, head_result_d;
  logic [2:0]       head_ctl_q, head_ctl_d;
  flags_t           head_flags_q, head_flags_d;
  logic [WIDTH-1:0] skid_result_q, skid_result_d;
  logic [2:0]       skid_ctl_q, skid_ctl_d;
  flags_t           skid_flags_q, skid_flags_d;
  logic             sticky_q, sticky_d;

  flags_t           in_flags;
  logic             accept;
  logic             pop;

  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .result_i (bus.in_result),
    .ctl_i    (bus.in_ctl),
    .carry_i  (bus.in_carry),
    .ovf_i    (bus.in_ovf),
    .flags_o  (in_flags)
  );

  assign accept = bus.in_valid & in_ready_q;
  assign pop    = (state_q != ST_EMPTY) & bus.out_ready;

  // Occupancy FSM: decides where an accepted beat lands and refills the head.
  always_comb begin
    state_d       = state_q;
    head_result_d = head_result_q;
    head_ctl_d    = head_ctl_q;
    head_flags_d  = head_flags_q;
    skid_result_d = skid_result_q;
    skid_ctl_d    = skid_ctl_q;
    skid_flags_d  = skid_flags_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          head_result_d = bus.in_result;
          head_ctl_d    = bus.in_ctl;
          head_flags_d  = in_flags;
          state_d       = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          head_result_d = bus.in_result;
          head_ctl_d    = bus.in_ctl;
          head_flags_d  = in_flags;
        end else if (accept) begin
          skid_result_d = bus.in_result;
          skid_ctl_d    = bus.in_ctl;
          skid_flags_d  = in_flags;
          state_d       = ST_TWO;
        end else if (pop) begin
          state_d       = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop) begin
          head_result_d = skid_result_q;
          head_ctl_d    = skid_ctl_q;
          head_flags_d  = skid_flags_q;
          state_d       = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    in_ready_d = (state_d != ST_TWO);
  end

  // Sticky overflow: a popped overflowing entry beats a simultaneous clear.
  always_comb begin
    sticky_d = sticky_q;
    if (pop && head_flags_q.ovf) begin
      sticky_d = 1'b1;
    end else if (clr_sticky_i) begin
      sticky_d = 1'b0;
    end
  end

  // State registers; reset discards both entries and ignores any handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_EMPTY;
      in_ready_q    <= 1'b1;
      head_result_q <= '0;
      head_ctl_q    <= '0;
      head_flags_q  <= '0;
      skid_result_q <= '0;
      skid_ctl_q    <= '0;
      skid_flags_q  <= '0;
      sticky_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      head_result_q <= head_result_d;
      head_ctl_q    <= head_ctl_d;
      head_flags_q  <= head_flags_d;
      skid_result_q <= skid_result_d;
      skid_ctl_q    <= skid_ctl_d;
      skid_flags_q  <= skid_flags_d;
      sticky_q      <= sticky_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = (state_q != ST_EMPTY);
  assign bus.out_result = head_result_q;
  assign bus.out_ctl    = head_ctl_q;
  assign bus.out_zero   = head_flags_q.zero;
  assign bus.out_neg    = head_flags_q.neg;
  assign bus.out_carry  = head_flags_q.carry;
  assign bus.out_ovf    = head_flags_q.ovf;
  assign sticky_ovf_o   = sticky_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for the ALU result stage: hand-computed expectations checked
// one cycle step at a time, sampled 1 time unit after each rising edge.
module tb_alu_result_stage;

  logic clk;
  logic reset;
  logic clr_sticky;
  logic sticky_ovf;
  int   checks;
  int   errors;

  alu_result_stage_if #(.WIDTH(32)) bus_if ();

  alu_result_stage #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus_if.slave),
    .clr_sticky_i (clr_sticky),
    .sticky_ovf_o (sticky_ovf)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic [2:0] c,
                       input logic cy, input logic ov);
    bus_if.in_valid  = v;
    bus_if.in_result = r;
    bus_if.in_ctl    = c;
    bus_if.in_carry  = cy;
    bus_if.in_ovf    = ov;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Directed sequence covering reset, flags, stall/skid, streaming, sticky and reset-with-data.
  initial begin
    logic [31:0] beat;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    clr_sticky = 1'b0;
    bus_if.out_ready = 1'b0;
    drive(1'b1, 32'hDEAD_BEEF, 3'd0, 1'b1, 1'b1);
    step();
    step();
    reset = 1'b0;
    drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    checkOutput("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    checkOutput("rst_sticky", 32'(sticky_ovf), 32'd0);
    checkOutput("rst_result", bus_if.out_result, 32'd0);

    // Zero result from an ADD with carry.
    drive(1'b1, 32'h0000_0000, 3'd0, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    checkOutput("add_valid", 32'(bus_if.out_valid), 32'd1);
    checkOutput("add_zero", 32'(bus_if.out_zero), 32'd1);
    checkOutput("add_neg", 32'(bus_if.out_neg), 32'd0);
    checkOutput("add_carry", 32'(bus_if.out_carry), 32'd1);
    bus_if.out_ready = 1'b1;
    step();
    bus_if.out_ready = 1'b0;
    checkOutput("add_popped", 32'(bus_if.out_valid), 32'd0);

    // Non-arith op masks carry/ovf.
    drive(1'b1, 32'h8000_0000, 3'd5, 1'b1, 1'b1);
    step();
    drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    checkOutput("sll_neg", 32'(bus_if.out_neg), 32'd1);
    checkOutput("sll_zero", 32'(bus_if.out_zero), 32'd0);
    checkOutput("sll_carry", 32'(bus_if.out_carry), 32'd0);
    checkOutput("sll_ovf", 32'(bus_if.out_ovf), 32'd0);
    checkOutput("sll_ctl", 32'(bus_if.out_ctl), 32'd5);
    bus_if.out_ready = 1'b1;
    step();
    bus_if.out_ready = 1'b0;
    checkOutput("sll_sticky", 32'(sticky_ovf), 32'd0);

    // Stall with A, B, C back to back.
    drive(1'b1, 32'hA, 3'd2, 1'b0, 1'b0);
    step();
    checkOutput("stall_a_ready", 32'(bus_if.in_ready), 32'd1);
    drive(1'b1, 32'hB, 3'd3, 1'b0, 1'b0);
    step();
    checkOutput("stall_b_ready", 32'(bus_if.in_ready), 32'd0);
    drive(1'b1, 32'hC, 3'd4, 1'b0, 1'b0);
    step();
    checkOutput("stall_c_held", 32'(bus_if.in_ready), 32'd0);
    checkOutput("stall_head_a", bus_if.out_result, 32'hA);
    checkOutput("stall_valid", 32'(bus_if.out_valid), 32'd1);
    bus_if.out_ready = 1'b1;
    step();
    checkOutput("drain_head_b", bus_if.out_result, 32'hB);
    checkOutput("drain_ready_up", 32'(bus_if.in_ready), 32'd1);
    step();
    drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    checkOutput("drain_head_c", bus_if.out_result, 32'hC);
    checkOutput("drain_c_valid", 32'(bus_if.out_valid), 32'd1);
    step();
    checkOutput("drain_empty", 32'(bus_if.out_valid), 32'd0);

    // Streaming eight beats at full rate.
    for (int i = 0; i < 8; i++) begin
      beat = 32'h1000_0000 + 32'(i * 3);
      drive(1'b1, beat, 3'd0, 1'b0, 1'b0);
      step();
      checkOutput("stream_ready", 32'(bus_if.in_ready), 32'd1);
      checkOutput("stream_valid", 32'(bus_if.out_valid), 32'd1);
      checkOutput("stream_data", bus_if.out_result, beat);
    end
    drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    step();
    checkOutput("stream_end", 32'(bus_if.out_valid), 32'd0);
    bus_if.out_ready = 1'b0;

    // SUB overflow popped together with clear: set wins.
    drive(1'b1, 32'h5, 3'd1, 1'b0, 1'b1);
    step();
    drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    checkOutput("sub_ovf", 32'(bus_if.out_ovf), 32'd1);
    bus_if.out_ready = 1'b1;
    clr_sticky = 1'b1;
    step();
    bus_if.out_ready = 1'b0;
    clr_sticky = 1'b0;
    checkOutput("sticky_set_wins", 32'(sticky_ovf), 32'd1);
    step();
    checkOutput("sticky_hold", 32'(sticky_ovf), 32'd1);
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    checkOutput("sticky_cleared", 32'(sticky_ovf), 32'd0);

    // Fill to TWO with a sticky set, then reset mid-operation.
    drive(1'b1, 32'hD, 3'd0, 1'b0, 1'b1);
    step();
    drive(1'b1, 32'hE, 3'd2, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    bus_if.out_ready = 1'b1;
    step();
    bus_if.out_ready = 1'b0;
    checkOutput("pre_rst_sticky", 32'(sticky_ovf), 32'd1);
    checkOutput("pre_rst_head_e", bus_if.out_result, 32'hE);
    drive(1'b1, 32'hF, 3'd2, 1'b0, 1'b0);
    step();
    checkOutput("pre_rst_full", 32'(bus_if.in_ready), 32'd0);
    reset = 1'b1;
    bus_if.out_ready = 1'b1;
    drive(1'b1, 32'h6, 3'd0, 1'b0, 1'b1);
    step();
    reset = 1'b0;
    bus_if.out_ready = 1'b0;
    drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    checkOutput("mid_rst_valid", 32'(bus_if.out_valid), 32'd0);
    checkOutput("mid_rst_ready", 32'(bus_if.in_ready), 32'd1);
    checkOutput("mid_rst_sticky", 32'(sticky_ovf), 32'd0);
    checkOutput("mid_rst_result", bus_if.out_result, 32'd0);
    drive(1'b1, 32'h1234_5678, 3'd1, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    checkOutput("post_rst_head", bus_if.out_result, 32'h1234_5678);
    checkOutput("post_rst_valid", 32'(bus_if.out_valid), 32'd1);
    bus_if.out_ready = 1'b1;
    step();
    checkOutput("post_rst_alone", 32'(bus_if.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
